// File: rtl/verifier_ctrl_pkg.sv
// Shared control-path types for the verifier front-end blocks.
// Holds the collector FSM state encoding.
package verifier_ctrl_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } collector_state_t;

endpackage

// File: rtl/verifier_parts_collector.sv
// Serial-to-parallel collector feeding verifier_adder_tree; tree_en one cycle after last write, in_ready low while a sum is in flight.
// Optional early launch with zero-fill is enabled by VERIFIER_COLLECTOR_FLUSH_EN.
`ifndef F_NBITS
`define F_NBITS 32
`endif

module verifier_parts_collector
  import verifier_ctrl_pkg::*;
#(
  parameter int ngates = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [`F_NBITS-1:0]           in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          tree_en,
  output logic [`F_NBITS*ngates-1:0]    v_parts,
  input  logic                          tree_ready,
  output logic                          busy,
  output logic                          done_pulse,
  output logic [$clog2(ngates+1)-1:0]   count
);

  localparam int FW = `F_NBITS;
  localparam int CW = $clog2(ngates+1);

  collector_state_t      state_q;
  logic [FW*ngates-1:0]  parts_q, parts_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  launch_d;
  logic                  tree_en_q;
  logic                  done_q;

  always_comb begin
    parts_d  = parts_q;
    count_d  = count_q;
    launch_d = 1'b0;
    if (state_q == FILL) begin
      if (in_valid) begin
        for (int i = 0; i < ngates; i++) begin
          if (CW'(i) == count_q) parts_d[i*FW +: FW] = in_data;
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(ngates-1)) launch_d = 1'b1;
      end
`ifdef VERIFIER_COLLECTOR_FLUSH_EN
      // A datum arriving with flush keeps its slot; zero-fill starts after it.
      if (flush) begin
        for (int i = 0; i < ngates; i++) begin
          if ((CW'(i) > count_q) || ((CW'(i) == count_q) && !in_valid))
            parts_d[i*FW +: FW] = '0;
        end
        count_d  = CW'(ngates);
        launch_d = 1'b1;
      end
`endif
    end
  end

`ifndef VERIFIER_COLLECTOR_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      parts_q   <= '0;
      count_q   <= '0;
      tree_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        FILL: begin
          parts_q <= parts_d;
          count_q <= count_d;
          if (launch_d) begin
            state_q   <= LAUNCH;
            tree_en_q <= 1'b1;
          end
        end
        // ready stays high until the tree has seen the en edge
        LAUNCH: begin
          if (!tree_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (tree_ready) begin
            state_q   <= FILL;
            count_q   <= '0;
            tree_en_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= FILL;
          tree_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == FILL);
  assign busy       = (state_q != FILL);
  assign tree_en    = tree_en_q;
  assign v_parts    = parts_q;
  assign done_pulse = done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_verifier_parts_collector.sv
// Directed bench for verifier_parts_collector (ngates=4) with a behavioural adder tree.
`ifndef F_NBITS
`define F_NBITS 32
`endif

module tb_verifier_parts_collector;

  localparam int NG  = 4;
  localparam int FW  = `F_NBITS;
  localparam int CW  = $clog2(NG+1);
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [FW-1:0]     in_data;
  logic              in_ready;
  logic              flush;
  logic              tree_en;
  logic [FW*NG-1:0]  v_parts;
  logic              tree_ready;
  logic              busy;
  logic              done_pulse;
  logic [CW-1:0]     count;

  logic [FW-1:0]     tree_v;
  logic              en_prev;
  int                tcnt;

  int total = 0;
  int bad   = 0;
  int stab_err;

  verifier_parts_collector #(.ngates(NG)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .tree_en    (tree_en),
    .v_parts    (v_parts),
    .tree_ready (tree_ready),
    .busy       (busy),
    .done_pulse (done_pulse),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Adder tree stand-in: ready drops on the en rising edge, result after LAT cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_ready <= 1'b1;
      en_prev    <= 1'b0;
      tcnt       <= 0;
      tree_v     <= '0;
    end else begin
      en_prev <= tree_en;
      if (tree_en && !en_prev) begin
        tree_ready <= 1'b0;
        tcnt       <= LAT;
      end else if (!tree_ready) begin
        if (tcnt == 0) begin
          tree_ready <= 1'b1;
          tree_v     <= v_parts[0*FW +: FW] + v_parts[1*FW +: FW]
                      + v_parts[2*FW +: FW] + v_parts[3*FW +: FW];
        end else begin
          tcnt <= tcnt - 1;
        end
      end
    end
  end

  function automatic logic [FW*NG-1:0] pk(input logic [FW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [FW*NG-1:0] obs, input logic [FW*NG-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [FW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
  endtask

  // Waits (bounded) for done_pulse while checking v_parts/in_ready stay frozen.
  task automatic wait_done(input logic [FW*NG-1:0] exp_parts, input logic drop,
                           output logic found, output logic [FW-1:0] vv);
    found    = 1'b0;
    vv       = 'x;
    stab_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_pulse) begin
        found = 1'b1;
        vv    = tree_v;
        if (drop) in_valid = 1'b0;
        break;
      end
      if (busy && ((v_parts !== exp_parts) || (in_ready !== 1'b0))) stab_err++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic          found;
    logic [FW-1:0] vv;
    int            extra;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", in_ready, 1);
    chk("rst_tree_en", tree_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_count", count, 0);
    chk("rst_parts", v_parts, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sum 1+2+3+4 with garbage on in_valid while busy.
    wr(1); wr(2); wr(3);
    chk("basic_count3", count, 3);
    chk("basic_en_before", tree_en, 0);
    wr(4);
    chk("basic_en_rise", tree_en, 1);
    chk("basic_busy", busy, 1);
    chk("basic_in_ready", in_ready, 0);
    chk("basic_parts", v_parts, pk(1, 2, 3, 4));
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    wait_done(pk(1, 2, 3, 4), 1'b1, found, vv);
    chk("basic_done_seen", found, 1);
    chk("basic_v", vv, 10);
    chk("stab_frozen", stab_err, 0);
    chk("basic_en_fall", tree_en, 0);
    chk("basic_count0", count, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_pulse) extra++;
    end
    chk("basic_single_pulse", extra, 0);
    chk("basic_no_garbage", count, 0);

    // Back-pressure: 9 held on the input across the busy window.
    wr(5); wr(6); wr(7); wr(8);
    in_data = 9;
    wait_done(pk(5, 6, 7, 8), 1'b0, found, vv);
    chk("bp_done_seen", found, 1);
    chk("bp_v", vv, 26);
    chk("bp_frozen", stab_err, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_count1", count, 1);
    chk("bp_slot0", v_parts[FW-1:0], 9);
    wr(10); wr(11); wr(12);
    in_valid = 1'b0;
    wait_done(pk(9, 10, 11, 12), 1'b1, found, vv);
    chk("bp2_v", vv, 42);

`ifdef VERIFIER_COLLECTOR_FLUSH_EN
    wr(7); wr(8);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 9;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_parts", v_parts, pk(7, 8, 9, 0));
    chk("fl_en", tree_en, 1);
    wait_done(pk(7, 8, 9, 0), 1'b1, found, vv);
    chk("fl_v", vv, 24);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl0_parts", v_parts, 0);
    chk("fl0_en", tree_en, 1);
    wait_done(0, 1'b1, found, vv);
    chk("fl0_v", vv, 0);
`else
    wr(1); wr(2);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("nofl_busy", busy, 0);
    chk("nofl_en", tree_en, 0);
    chk("nofl_count", count, 2);
    wr(3);
    chk("nofl_en3", tree_en, 0);
    wr(4);
    in_valid = 1'b0;
    chk("nofl_en4", tree_en, 1);
    wait_done(pk(1, 2, 3, 4), 1'b1, found, vv);
    chk("nofl_v", vv, 10);
`endif

    // Reset while waiting on the tree.
    wr(2); wr(4); wr(6); wr(8);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rw_busy", busy, 1);
    chk("rw_tree_low", tree_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rw_en", tree_en, 0);
    chk("rw_count", count, 0);
    chk("rw_parts", v_parts, 0);
    chk("rw_busy0", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    wr(10); wr(20); wr(30); wr(40);
    in_valid = 1'b0;
    wait_done(pk(10, 20, 30, 40), 1'b1, found, vv);
    chk("rw_after_v", vv, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
